// File: rtl/outrun_key_prom.sv
// Out Run protection key store: 8 KB key RAM, decoder configuration latched from
// the download header, PROM region write strobes and the registered status-dump mux.
module outrun_key_prom #(
   parameter int          AW        = 13,
   parameter logic [24:0] KEY_START = 25'h0D0000,
   parameter logic [24:0] FD_START  = 25'h0D2000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [21:0]   prog_addr,
   input  logic [7:0]    prog_data,
   input  logic          prog_we,
   input  logic          prom_we,
   input  logic          header,
   input  logic          cen,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    q,
   output logic          key_we,
   output logic          fd1089_we,
   output logic          fd1089_en,
   output logic          fd1094_en,
   output logic          dec_type,
   output logic          dec_en,
   output logic [1:0]    game_id,
   input  logic [7:0]    st_addr,
   input  logic [7:0]    st_main,
   input  logic [7:0]    st_sub,
   input  logic [7:0]    st_video,
   input  logic [7:0]    sndmap_dout,
   input  logic [1:0]    obj_cfg,
   input  logic          obj_swap,
   input  logic          mute,
   input  logic          snd_rstb,
   input  logic          flip,
   input  logic          video_en,
   output logic [7:0]    st_dout
);

   localparam int DEPTH = 2 ** AW;

   logic [7:0] mem_q [0:DEPTH-1];
   logic [7:0] q_q;
   logic       fd1089_en_q, fd1089_en_d;
   logic       fd1094_en_q, fd1094_en_d;
   logic       dec_type_q,  dec_type_d;
   logic       dec_en_q,    dec_en_d;
   logic [1:0] game_id_q,   game_id_d;
   logic [7:0] st_dout_q,   st_dout_d;
   logic       unused_st_s;

   // st_addr[5:4] are don't-care bits of the status page decode
   assign unused_st_s = ^st_addr[5:4];

   assign key_we    = prom_we & (prog_addr[21:13] == KEY_START[21:13]);
   assign fd1089_we = prom_we & (prog_addr[21:8]  == FD_START[21:8]);

   // Key RAM: no reset so the table survives a core reset mid-session
   always_ff @(posedge clk) begin
      if (key_we) begin
         mem_q[prog_addr[AW-1:0]] <= prog_data;
      end
   end

   // Registered key read port; read-before-write on address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 8'h00;
      end else if (cen) begin
         q_q <= mem_q[rd_addr];
      end
   end

   // Header latch next-state: offset 0 carries decoder flags, offset 1 the game id
   always_comb begin
      fd1089_en_d = fd1089_en_q;
      fd1094_en_d = fd1094_en_q;
      dec_type_d  = dec_type_q;
      game_id_d   = game_id_q;
      dec_en_d    = fd1089_en_q | fd1094_en_q;
      case ({header & prog_we, prog_addr[3:0]})
         5'b1_0000: begin
            fd1089_en_d = prog_data[1];
            dec_type_d  = prog_data[0];
            fd1094_en_d = prog_data[2];
         end
         5'b1_0001: game_id_d = prog_data[1:0];
         default:   game_id_d = game_id_q;
      endcase
   end

   // Status dump select; unmapped debug slots keep the last byte shown
   always_comb begin
      st_dout_d = st_dout_q;
      case (st_addr[7:6])
         2'd0: st_dout_d = st_main;
         2'd1: st_dout_d = st_sub;
         2'd2: st_dout_d = st_video;
         2'd3: begin
            case (st_addr[3:0])
               4'd0:    st_dout_d = sndmap_dout;
               4'd1:    st_dout_d = {2'b00, obj_cfg, 3'b000, obj_swap};
               4'd2:    st_dout_d = {obj_cfg, mute, 2'b00, snd_rstb, game_id_q};
               4'd3:    st_dout_d = {3'b000, flip, 3'b000, video_en};
               default: st_dout_d = st_dout_q;
            endcase
         end
         default: st_dout_d = st_dout_q;
      endcase
   end

   // Configuration and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fd1089_en_q <= 1'b0;
         fd1094_en_q <= 1'b0;
         dec_type_q  <= 1'b0;
         dec_en_q    <= 1'b0;
         game_id_q   <= 2'b00;
         st_dout_q   <= 8'h00;
      end else begin
         fd1089_en_q <= fd1089_en_d;
         fd1094_en_q <= fd1094_en_d;
         dec_type_q  <= dec_type_d;
         dec_en_q    <= dec_en_d;
         game_id_q   <= game_id_d;
         st_dout_q   <= st_dout_d;
      end
   end

   assign q         = q_q;
   assign fd1089_en = fd1089_en_q;
   assign fd1094_en = fd1094_en_q;
   assign dec_type  = dec_type_q;
   assign dec_en    = dec_en_q;
   assign game_id   = game_id_q;
   assign st_dout   = st_dout_q;

endmodule

// File: tb/tb_outrun_key_prom.sv
// Self-checking bench for outrun_key_prom: scoreboard queue of expected read/status bytes.
module tb_outrun_key_prom;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic        prog_we, prom_we, header, cen;
   logic [12:0] rd_addr;
   logic [7:0]  q;
   logic        key_we, fd1089_we, fd1089_en, fd1094_en, dec_type, dec_en;
   logic [1:0]  game_id;
   logic [7:0]  st_addr, st_main, st_sub, st_video, sndmap_dout;
   logic [1:0]  obj_cfg;
   logic        obj_swap, mute, snd_rstb, flip, video_en;
   logic [7:0]  st_dout;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [7:0]  exp_q [$];
   string       tag_q [$];
   logic [7:0]  model [int];
   int          addrs [8];

   outrun_key_prom dut (
      .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_we(prog_we), .prom_we(prom_we), .header(header), .cen(cen),
      .rd_addr(rd_addr), .q(q), .key_we(key_we), .fd1089_we(fd1089_we),
      .fd1089_en(fd1089_en), .fd1094_en(fd1094_en), .dec_type(dec_type),
      .dec_en(dec_en), .game_id(game_id), .st_addr(st_addr), .st_main(st_main),
      .st_sub(st_sub), .st_video(st_video), .sndmap_dout(sndmap_dout),
      .obj_cfg(obj_cfg), .obj_swap(obj_swap), .mute(mute), .snd_rstb(snd_rstb),
      .flip(flip), .video_en(video_en), .st_dout(st_dout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [7:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic sb_pop(input logic [7:0] got);
      if (exp_q.size() == 0) begin
         check_eq("sb_underrun", 32'd1, 32'd0);
      end else begin
         check_eq(tag_q.pop_front(), {24'd0, got}, {24'd0, exp_q.pop_front()});
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // {q, st_dout, fd1089_en, fd1094_en, dec_type, dec_en, game_id}
   function automatic logic [31:0] obs();
      return {10'd0, q, st_dout, fd1089_en, fd1094_en, dec_type, dec_en, game_id};
   endfunction

   task automatic key_write(input logic [12:0] a, input logic [7:0] d);
      prog_addr = 22'h0D0000 | {9'd0, a};
      prog_data = d;
      prom_we   = 1'b1;
      tick();
      prom_we   = 1'b0;
      model[int'(a)] = d;
   endtask

   task automatic hdr_write(input logic hdr, input logic [3:0] off, input logic [7:0] d);
      header    = hdr;
      prog_we   = 1'b1;
      prog_addr = {18'd0, off};
      prog_data = d;
      tick();
      prog_we   = 1'b0;
      header    = 1'b0;
   endtask

   task automatic st_sel(input string tag, input logic [7:0] sa, input logic [7:0] e);
      st_addr = sa;
      sb_push(tag, e);
      tick();
      sb_pop(st_dout);
   endtask

   initial begin
      rst_n = 1'b1; prog_addr = 22'd0; prog_data = 8'd0; prog_we = 1'b0;
      prom_we = 1'b0; header = 1'b0; cen = 1'b0; rd_addr = 13'd0;
      st_addr = 8'd0; st_main = 8'd0; st_sub = 8'd0; st_video = 8'd0;
      sndmap_dout = 8'd0; obj_cfg = 2'd0; obj_swap = 1'b0; mute = 1'b0;
      snd_rstb = 1'b0; flip = 1'b0; video_en = 1'b0;

      #2 rst_n = 1'b0;
      #1 check_eq("reset_outputs", obs(), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      check_eq("idle_after_reset", obs(), 32'd0);

      // key load and hold-on-cen-low
      prog_addr = 22'h0D0005; prog_data = 8'hA5; prom_we = 1'b1;
      #1 check_eq("key_strobes", {30'd0, key_we, fd1089_we}, 32'd2);
      tick();
      prom_we = 1'b0;
      model[5] = 8'hA5;
      rd_addr = 13'd5; cen = 1'b1;
      sb_push("key_rd5", 8'hA5);
      tick();
      sb_pop(q);
      cen = 1'b0; rd_addr = 13'd6;
      tick();
      check_eq("q_hold_cen0", {24'd0, q}, 32'hA5);

      // window decode (no clock edge while strobing)
      prom_we = 1'b1;
      prog_addr = 22'h0D2010; #1 check_eq("win_fd", {30'd0, key_we, fd1089_we}, 32'd1);
      prog_addr = 22'h0D4000; #1 check_eq("win_none", {30'd0, key_we, fd1089_we}, 32'd0);
      prog_addr = 22'h0D1FFF; #1 check_eq("win_key_top", {30'd0, key_we, fd1089_we}, 32'd2);
      prog_addr = 22'h0D20FF; #1 check_eq("win_fd_top", {30'd0, key_we, fd1089_we}, 32'd1);
      prog_addr = 22'h0D2100; #1 check_eq("win_fd_past", {30'd0, key_we, fd1089_we}, 32'd0);
      prom_we = 1'b0;
      prog_addr = 22'h0D0005; #1 check_eq("win_no_we", {30'd0, key_we, fd1089_we}, 32'd0);

      // random key writes then pipelined readback
      for (int i = 0; i < 8; i++) begin
         addrs[i] = 16 + i * 768 + int'($urandom_range(0, 255));
         key_write(13'(addrs[i]), 8'($urandom));
      end
      cen = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rd_addr = 13'(addrs[i]);
         sb_push("key_rd_rand", model[addrs[i]]);
         tick();
         sb_pop(q);
      end
      cen = 1'b0;

      // header latch and dec_en latency
      hdr_write(1'b1, 4'd0, 8'h07);
      check_eq("hdr_flags", {29'd0, fd1089_en, fd1094_en, dec_type}, 32'd7);
      check_eq("dec_en_lag", {31'd0, dec_en}, 32'd0);
      tick();
      check_eq("dec_en_set", {31'd0, dec_en}, 32'd1);
      hdr_write(1'b1, 4'd1, 8'h02);
      check_eq("hdr_game_id", {30'd0, game_id}, 32'd2);
      hdr_write(1'b0, 4'd0, 8'h00);
      hdr_write(1'b0, 4'd1, 8'h01);
      check_eq("nohdr_ignored", {27'd0, fd1089_en, fd1094_en, dec_type, game_id}, 32'h1E);
      hdr_write(1'b1, 4'd2, 8'hFF);
      check_eq("hdr_off2_ignored", {27'd0, fd1089_en, fd1094_en, dec_type, game_id}, 32'h1E);
      hdr_write(1'b1, 4'd0, 8'h04);
      check_eq("hdr_fd1094_only", {29'd0, fd1089_en, fd1094_en, dec_type}, 32'd2);
      hdr_write(1'b1, 4'd0, 8'h00);
      check_eq("dec_en_still", {31'd0, dec_en}, 32'd1);
      tick();
      check_eq("dec_en_clear", {31'd0, dec_en}, 32'd0);

      // status mux
      st_main = 8'h5A; st_sub = 8'h3C; st_video = 8'h99; sndmap_dout = 8'h77;
      obj_cfg = 2'd3; obj_swap = 1'b1; mute = 1'b1; snd_rstb = 1'b1;
      flip = 1'b1; video_en = 1'b1;
      st_sel("st_main", 8'h00, 8'h5A);
      st_sel("st_sub", 8'h40, 8'h3C);
      st_sel("st_video", 8'h80, 8'h99);
      st_sel("st_snd", 8'hC0, 8'h77);
      st_sel("st_obj", 8'hC1, 8'h31);
      st_sel("st_cfg", 8'hC2, 8'hE6);
      st_sel("st_cfg_alias", 8'hF2, 8'hE6);
      st_sel("st_video_en", 8'hC3, 8'h11);
      st_sel("st_hold_c7", 8'hC7, 8'h11);
      st_sel("st_hold_cf", 8'hCF, 8'h11);

      // same-address read/write collision
      key_write(13'd9, 8'h11);
      rd_addr = 13'd9; cen = 1'b1;
      prog_addr = 22'h0D0009; prog_data = 8'h22; prom_we = 1'b1;
      sb_push("rw_old", 8'h11);
      tick();
      sb_pop(q);
      prom_we = 1'b0;
      sb_push("rw_new", 8'h22);
      tick();
      sb_pop(q);
      cen = 1'b0;

      // reset mid-download clears latches but not key RAM
      hdr_write(1'b1, 4'd0, 8'h07);
      prom_we = 1'b1; prog_addr = 22'h0D0100; prog_data = 8'h5E;
      #2 rst_n = 1'b0;
      #1 check_eq("midreset_outputs", obs(), 32'd0);
      prom_we = 1'b0;
      tick();
      rst_n = 1'b1;
      rd_addr = 13'd5; cen = 1'b1;
      sb_push("key_retained", 8'hA5);
      tick();
      sb_pop(q);
      cen = 1'b0;

      check_eq("sb_drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
